// File: rtl/spi_master_slave.sv
// ---------------------------------------------------------------------------
// spi_master_slave
//
// Independent SPI mode-0 (CPOL=0, CPHA=0, MSB first) master and slave halves
// sharing only the system clock and reset.
//
// Parameters
//   p_WORD_LEN : bits per SPI word for both halves (>= 2)
//   p_CLK_DIV  : i_clk cycles per o_sclk half-period (even, >= 4)
//
// Ports
//   i_clk, i_rst_n            : system clock (rising edge), async active-low reset
//   Master SPI                : i_miso in, o_sclk / o_mosi out
//   Master input method       : m_inp_data, m_inp_en in; m_inp_rdy out (idle)
//   Master output method      : m_out_data (last received word), m_out_rdy strobe
//   Slave SPI                 : i_sclk, i_mosi, i_ss (active-low) in; o_miso out
//   Slave input method        : s_inp_data, s_inp_en in; s_inp_rdy out
//   Slave output method       : s_out_data (last received word), s_out_rdy strobe
// ---------------------------------------------------------------------------
module spi_master_slave #(
  parameter int p_WORD_LEN = 8,
  parameter int p_CLK_DIV  = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // master half
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic [p_WORD_LEN-1:0] m_inp_data,
  input  logic                  m_inp_en,
  output logic                  m_inp_rdy,
  output logic [p_WORD_LEN-1:0] m_out_data,
  output logic                  m_out_rdy,
  // slave half
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss,
  output logic                  o_miso,
  input  logic [p_WORD_LEN-1:0] s_inp_data,
  input  logic                  s_inp_en,
  output logic                  s_inp_rdy,
  output logic [p_WORD_LEN-1:0] s_out_data,
  output logic                  s_out_rdy
);

  localparam int DIV_W = $clog2(p_CLK_DIV);
  localparam int BIT_W = $clog2(p_WORD_LEN);
  localparam int CNT_W = $clog2(p_WORD_LEN + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(p_CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(p_WORD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(p_WORD_LEN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    DONE     = 2'd2
  } m_state_e;

  // master state
  m_state_e              m_state_q, m_state_d;
  logic [p_WORD_LEN-1:0] m_shreg_q, m_shreg_d;
  logic [DIV_W-1:0]      m_div_q, m_div_d;
  logic [BIT_W-1:0]      m_bit_q, m_bit_d;
  logic                  m_sclk_q, m_sclk_d;
  logic                  m_mosi_q, m_mosi_d;
  logic                  m_miso_smp_q, m_miso_smp_d;
  logic [p_WORD_LEN-1:0] m_out_data_q, m_out_data_d;
  logic                  m_out_rdy_q, m_out_rdy_d;
  logic                  m_inp_rdy_q, m_inp_rdy_d;

  // slave state; sclk_sync keeps one extra stage for edge detection
  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic [1:0]            ss_sync_q, ss_sync_d;
  logic [p_WORD_LEN-1:0] s_shreg_q, s_shreg_d;
  logic [CNT_W-1:0]      s_cnt_q, s_cnt_d;
  logic                  s_cap_q, s_cap_d;
  logic [p_WORD_LEN-1:0] s_out_data_q, s_out_data_d;
  logic                  s_out_rdy_q, s_out_rdy_d;

  logic s_sclk_rise;
  logic s_sclk_fall;

  assign s_sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign s_sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

  // Master: the divider runs only in TRANSFER; every p_CLK_DIV cycles sclk
  // toggles. Low->high samples MISO, high->low shifts it in and advances MOSI.
  always_comb begin
    m_state_d    = m_state_q;
    m_shreg_d    = m_shreg_q;
    m_div_d      = m_div_q;
    m_bit_d      = m_bit_q;
    m_sclk_d     = m_sclk_q;
    m_mosi_d     = m_mosi_q;
    m_miso_smp_d = m_miso_smp_q;
    m_out_data_d = m_out_data_q;
    m_out_rdy_d  = 1'b0;
    m_inp_rdy_d  = m_inp_rdy_q;
    case (m_state_q)
      IDLE: begin
        m_sclk_d = 1'b0;
        if (m_inp_en) begin
          m_shreg_d   = m_inp_data;
          m_mosi_d    = m_inp_data[p_WORD_LEN-1];
          m_div_d     = '0;
          m_bit_d     = '0;
          m_inp_rdy_d = 1'b0;
          m_state_d   = TRANSFER;
        end
      end
      TRANSFER: begin
        if (m_div_q == DIV_LAST) begin
          m_div_d  = '0;
          m_sclk_d = ~m_sclk_q;
          if (!m_sclk_q) begin
            m_miso_smp_d = i_miso;
          end else begin
            m_shreg_d = {m_shreg_q[p_WORD_LEN-2:0], m_miso_smp_q};
            m_mosi_d  = m_shreg_q[p_WORD_LEN-2];
            if (m_bit_q == BIT_LAST) begin
              m_out_data_d = {m_shreg_q[p_WORD_LEN-2:0], m_miso_smp_q};
              m_out_rdy_d  = 1'b1;
              m_state_d    = DONE;
            end else begin
              m_bit_d = m_bit_q + 1'b1;
            end
          end
        end else begin
          m_div_d = m_div_q + 1'b1;
        end
      end
      DONE: begin
        m_inp_rdy_d = 1'b1;
        m_state_d   = IDLE;
      end
      default: begin
        m_inp_rdy_d = 1'b1;
        m_state_d   = IDLE;
      end
    endcase
  end

  // Slave: a completed word (counter at p_WORD_LEN) is published before a
  // deselect is honoured, so a late SS rise never swallows a full word.
  // The shift register is not reloaded on completion, which gives the
  // daisy-chain pass-through behaviour.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], i_sclk};
    mosi_sync_d  = {mosi_sync_q[0], i_mosi};
    ss_sync_d    = {ss_sync_q[0], i_ss};
    s_shreg_d    = s_shreg_q;
    s_cnt_d      = s_cnt_q;
    s_cap_d      = s_cap_q;
    s_out_data_d = s_out_data_q;
    s_out_rdy_d  = 1'b0;
    if (s_cnt_q == CNT_FULL) begin
      s_cnt_d      = '0;
      s_out_data_d = s_shreg_q;
      s_out_rdy_d  = 1'b1;
    end else if (ss_sync_q[1]) begin
      s_cnt_d = '0;
    end else begin
      if (s_sclk_rise) begin
        s_cap_d = mosi_sync_q[1];
      end
      if (s_sclk_fall) begin
        s_shreg_d = {s_shreg_q[p_WORD_LEN-2:0], s_cap_q};
        s_cnt_d   = s_cnt_q + 1'b1;
      end
    end
    if (s_inp_en && (s_cnt_q == '0)) begin
      s_shreg_d = s_inp_data;
    end
  end

  // All state, both halves; the SS synchroniser resets to "deselected".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_state_q    <= IDLE;
      m_shreg_q    <= '0;
      m_div_q      <= '0;
      m_bit_q      <= '0;
      m_sclk_q     <= 1'b0;
      m_mosi_q     <= 1'b0;
      m_miso_smp_q <= 1'b0;
      m_out_data_q <= '0;
      m_out_rdy_q  <= 1'b0;
      m_inp_rdy_q  <= 1'b1;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ss_sync_q    <= 2'b11;
      s_shreg_q    <= '0;
      s_cnt_q      <= '0;
      s_cap_q      <= 1'b0;
      s_out_data_q <= '0;
      s_out_rdy_q  <= 1'b0;
    end else begin
      m_state_q    <= m_state_d;
      m_shreg_q    <= m_shreg_d;
      m_div_q      <= m_div_d;
      m_bit_q      <= m_bit_d;
      m_sclk_q     <= m_sclk_d;
      m_mosi_q     <= m_mosi_d;
      m_miso_smp_q <= m_miso_smp_d;
      m_out_data_q <= m_out_data_d;
      m_out_rdy_q  <= m_out_rdy_d;
      m_inp_rdy_q  <= m_inp_rdy_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ss_sync_q    <= ss_sync_d;
      s_shreg_q    <= s_shreg_d;
      s_cnt_q      <= s_cnt_d;
      s_cap_q      <= s_cap_d;
      s_out_data_q <= s_out_data_d;
      s_out_rdy_q  <= s_out_rdy_d;
    end
  end

  assign o_sclk     = m_sclk_q;
  assign o_mosi     = m_mosi_q;
  assign m_inp_rdy  = m_inp_rdy_q;
  assign m_out_data = m_out_data_q;
  assign m_out_rdy  = m_out_rdy_q;

  assign o_miso     = ~ss_sync_q[1] & s_shreg_q[p_WORD_LEN-1];
  assign s_inp_rdy  = (s_cnt_q == '0);
  assign s_out_data = s_out_data_q;
  assign s_out_rdy  = s_out_rdy_q;

endmodule

// File: tb/tb_spi_master_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_master_slave
//
// Two instances: dut_a provides the master and the first slave, dut_b the
// second slave of a daisy chain. loop_mode selects whether the master's MISO
// comes back from dut_a's slave (single loopback) or from dut_b's slave.
// ---------------------------------------------------------------------------
module tb_spi_master_slave;

  logic clk;
  logic rst_n;
  logic loop_mode;
  logic ss_a;
  logic ss_b;

  logic [7:0] m_inp_data;
  logic       m_inp_en;
  logic [7:0] a_s_inp_data;
  logic       a_s_inp_en;
  logic [7:0] b_s_inp_data;
  logic       b_s_inp_en;

  logic       a_o_sclk, a_o_mosi, a_m_inp_rdy, a_m_out_rdy;
  logic [7:0] a_m_out_data;
  logic       a_o_miso, a_s_inp_rdy, a_s_out_rdy;
  logic [7:0] a_s_out_data;
  logic       a_i_miso;

  logic       b_o_sclk, b_o_mosi, b_m_inp_rdy, b_m_out_rdy;
  logic [7:0] b_m_out_data;
  logic       b_o_miso, b_s_inp_rdy, b_s_out_rdy;
  logic [7:0] b_s_out_data;

  int vectors;
  int miscompares;
  int m_strobes;
  int a_strobes;
  int b_strobes;
  int n_rise;
  int n_fall;
  longint rise_t [32];

  assign a_i_miso = loop_mode ? a_o_miso : b_o_miso;

  spi_master_slave #(.p_WORD_LEN(8), .p_CLK_DIV(10)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_miso(a_i_miso), .o_sclk(a_o_sclk), .o_mosi(a_o_mosi),
    .m_inp_data(m_inp_data), .m_inp_en(m_inp_en), .m_inp_rdy(a_m_inp_rdy),
    .m_out_data(a_m_out_data), .m_out_rdy(a_m_out_rdy),
    .i_sclk(a_o_sclk), .i_mosi(a_o_mosi), .i_ss(ss_a), .o_miso(a_o_miso),
    .s_inp_data(a_s_inp_data), .s_inp_en(a_s_inp_en), .s_inp_rdy(a_s_inp_rdy),
    .s_out_data(a_s_out_data), .s_out_rdy(a_s_out_rdy)
  );

  spi_master_slave #(.p_WORD_LEN(8), .p_CLK_DIV(10)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_miso(1'b0), .o_sclk(b_o_sclk), .o_mosi(b_o_mosi),
    .m_inp_data(8'h00), .m_inp_en(1'b0), .m_inp_rdy(b_m_inp_rdy),
    .m_out_data(b_m_out_data), .m_out_rdy(b_m_out_rdy),
    .i_sclk(a_o_sclk), .i_mosi(a_o_miso), .i_ss(ss_b), .o_miso(b_o_miso),
    .s_inp_data(b_s_inp_data), .s_inp_en(b_s_inp_en), .s_inp_rdy(b_s_inp_rdy),
    .s_out_data(b_s_out_data), .s_out_rdy(b_s_out_rdy)
  );

  // 10-unit system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobes last exactly one cycle, so sampling on the falling edge counts
  // each one once.
  always @(negedge clk) begin
    if (a_m_out_rdy) m_strobes <= m_strobes + 1;
    if (a_s_out_rdy) a_strobes <= a_strobes + 1;
    if (b_s_out_rdy) b_strobes <= b_strobes + 1;
  end

  // Master serial clock edge bookkeeping for period and bit-position checks
  always @(posedge a_o_sclk) begin
    rise_t[n_rise % 32] = $time;
    n_rise = n_rise + 1;
  end

  always @(negedge a_o_sclk) begin
    n_fall = n_fall + 1;
  end

  // Hard stop in case some wait is never satisfied
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse the master request for one cycle and confirm it left IDLE
  task automatic applyStimulus(input logic [7:0] word);
    @(negedge clk);
    m_inp_data = word;
    m_inp_en   = 1'b1;
    @(negedge clk);
    m_inp_en   = 1'b0;
    checkOutput("m_inp_rdy_low_after_start", {31'd0, a_m_inp_rdy}, 32'd0);
  endtask

  // Wait (bounded) for the master strobe, check the return to IDLE, then let
  // the slaves finish publishing their words
  task automatic waitDone(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_m_out_rdy) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_rdy_back"}, {31'd0, a_m_inp_rdy}, 32'd1);
    checkOutput({tag, "_strobe_one_cycle"}, {31'd0, a_m_out_rdy}, 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic loadSlaves(input logic ld_a, input logic [7:0] va,
                            input logic ld_b, input logic [7:0] vb);
    @(negedge clk);
    a_s_inp_data = va;
    a_s_inp_en   = ld_a;
    b_s_inp_data = vb;
    b_s_inp_en   = ld_b;
    @(negedge clk);
    a_s_inp_en = 1'b0;
    b_s_inp_en = 1'b0;
  endtask

  initial begin
    int base_m, base_a, base_b, base_r, base_f;
    vectors = 0; miscompares = 0;
    m_strobes = 0; a_strobes = 0; b_strobes = 0;
    n_rise = 0; n_fall = 0;
    rst_n = 1'b0; loop_mode = 1'b1; ss_a = 1'b1; ss_b = 1'b1;
    m_inp_data = '0; m_inp_en = 1'b0;
    a_s_inp_data = '0; a_s_inp_en = 1'b0;
    b_s_inp_data = '0; b_s_inp_en = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_o_sclk", {31'd0, a_o_sclk}, 32'd0);
    checkOutput("rst_o_mosi", {31'd0, a_o_mosi}, 32'd0);
    checkOutput("rst_m_inp_rdy", {31'd0, a_m_inp_rdy}, 32'd1);
    checkOutput("rst_m_out_data", {24'd0, a_m_out_data}, 32'h00);
    checkOutput("rst_s_inp_rdy", {31'd0, a_s_inp_rdy}, 32'd1);
    checkOutput("rst_o_miso", {31'd0, a_o_miso}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ss_a  = 1'b0;
    repeat (4) @(negedge clk);

    // Single loopback: slave holds 0x3C, master sends 0xA5; also timing
    loadSlaves(1'b1, 8'h3C, 1'b0, 8'h00);
    base_m = m_strobes; base_a = a_strobes; base_r = n_rise;
    applyStimulus(8'hA5);
    waitDone("loop");
    checkOutput("loop_m_out_data", {24'd0, a_m_out_data}, 32'h3C);
    checkOutput("loop_s_out_data", {24'd0, a_s_out_data}, 32'hA5);
    checkOutput("loop_m_strobes", m_strobes - base_m, 32'd1);
    checkOutput("loop_s_strobes", a_strobes - base_a, 32'd1);
    checkOutput("loop_sclk_rises", n_rise - base_r, 32'd8);
    for (int i = 1; i < 8; i++) begin
      checkOutput("loop_sclk_period",
                  32'(rise_t[(base_r + i) % 32] - rise_t[(base_r + i - 1) % 32]), 32'd200);
    end

    // Daisy chain: master -> slave A -> slave B -> master
    loop_mode = 1'b0;
    ss_b      = 1'b0;
    repeat (4) @(negedge clk);
    loadSlaves(1'b1, 8'h00, 1'b1, 8'h55);
    base_m = m_strobes; base_a = a_strobes; base_b = b_strobes;
    applyStimulus(8'hAA);
    waitDone("chain1");
    checkOutput("chain1_m_out_data", {24'd0, a_m_out_data}, 32'h55);
    checkOutput("chain1_s1_out_data", {24'd0, a_s_out_data}, 32'hAA);
    checkOutput("chain1_s2_out_data", {24'd0, b_s_out_data}, 32'h00);
    checkOutput("chain1_strobes", {m_strobes - base_m, a_strobes - base_a, b_strobes - base_b}
                == {32'd1, 32'd1, 32'd1} ? 32'd1 : 32'd0, 32'd1);

    // Continue without reload: slaves pass through what they received
    base_a = a_strobes; base_b = b_strobes;
    applyStimulus(8'hFF);
    waitDone("chain2");
    checkOutput("chain2_m_out_data", {24'd0, a_m_out_data}, 32'h00);
    checkOutput("chain2_s1_out_data", {24'd0, a_s_out_data}, 32'hFF);
    checkOutput("chain2_s2_out_data", {24'd0, b_s_out_data}, 32'hAA);
    checkOutput("chain2_s1_strobes", a_strobes - base_a, 32'd1);
    checkOutput("chain2_s2_strobes", b_strobes - base_b, 32'd1);

    // Deselect after 3 bits: no slave strobe; master sees 110 then zeros
    loop_mode = 1'b1;
    ss_b      = 1'b1;
    loadSlaves(1'b1, 8'hC3, 1'b0, 8'h00);
    base_a = a_strobes; base_f = n_fall;
    applyStimulus(8'h5A);
    for (int i = 0; i < 1000 && n_fall < base_f + 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    ss_a = 1'b1;
    waitDone("partial");
    checkOutput("partial_m_out_data", {24'd0, a_m_out_data}, 32'hC0);
    checkOutput("partial_no_s_strobe", a_strobes - base_a, 32'd0);
    checkOutput("partial_s_inp_rdy", {31'd0, a_s_inp_rdy}, 32'd1);
    checkOutput("partial_o_miso_desel", {31'd0, a_o_miso}, 32'd0);
    ss_a = 1'b0;
    repeat (4) @(negedge clk);
    loadSlaves(1'b1, 8'h69, 1'b0, 8'h00);
    base_a = a_strobes;
    applyStimulus(8'h96);
    waitDone("after_partial");
    checkOutput("after_partial_m_out", {24'd0, a_m_out_data}, 32'h69);
    checkOutput("after_partial_s_out", {24'd0, a_s_out_data}, 32'h96);
    checkOutput("after_partial_s_strobes", a_strobes - base_a, 32'd1);

    // Reset mid-word while sclk is high and MOSI carries a 1
    loadSlaves(1'b1, 8'h12, 1'b0, 8'h00);
    base_m = m_strobes; base_a = a_strobes; base_f = n_fall;
    applyStimulus(8'hF0);
    for (int i = 0; i < 1000 && n_fall < base_f + 2; i++) @(negedge clk);
    repeat (13) @(negedge clk);
    checkOutput("pre_rst_sclk_high", {31'd0, a_o_sclk}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_o_sclk", {31'd0, a_o_sclk}, 32'd0);
    checkOutput("midrst_o_mosi", {31'd0, a_o_mosi}, 32'd0);
    checkOutput("midrst_m_inp_rdy", {31'd0, a_m_inp_rdy}, 32'd1);
    checkOutput("midrst_m_out_rdy", {31'd0, a_m_out_rdy}, 32'd0);
    checkOutput("midrst_m_out_data", {24'd0, a_m_out_data}, 32'h00);
    checkOutput("midrst_s_out_data", {24'd0, a_s_out_data}, 32'h00);
    checkOutput("midrst_s_out_rdy", {31'd0, a_s_out_rdy}, 32'd0);
    checkOutput("midrst_s_inp_rdy", {31'd0, a_s_inp_rdy}, 32'd1);
    checkOutput("midrst_o_miso", {31'd0, a_o_miso}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("midrst_no_m_strobe", m_strobes - base_m, 32'd0);
    checkOutput("midrst_no_s_strobe", a_strobes - base_a, 32'd0);
    loadSlaves(1'b1, 8'h81, 1'b0, 8'h00);
    applyStimulus(8'h7E);
    waitDone("post_rst");
    checkOutput("post_rst_m_out", {24'd0, a_m_out_data}, 32'h81);
    checkOutput("post_rst_s_out", {24'd0, a_s_out_data}, 32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
